// File: rtl/spm_pkg.sv
// Shared types and constants for the signed serial-parallel multiplier
// sequencing controller (spm_seq_ctrl) and its bit counter.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } spm_state_t;

  // Default operand width; the product is twice this wide.
  localparam int SPM_N = 8;

  // Bit-counter width, wide enough for indices 0..2N (5 bits for N=8).
  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

  // Index of the final serial bit of a multiply.
  function automatic int last_bit(input int n);
    return 2 * n - 1;
  endfunction

  localparam int CNT_W    = cnt_width(SPM_N);
  localparam int LAST_BIT = last_bit(SPM_N);

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Handshake/control bundle between the operand-issuing logic (master)
// and the SPM sequencing controller (slave).
// Optional macro SPM_CTRL_ABORT_EN adds the abort request line.
interface spm_seq_ctrl_if
  import spm_pkg::*;
#(
  parameter int N     = SPM_N,
  parameter int CNT_W = cnt_width(N)
);

  logic             start;
  logic             ack;
  logic             ready;
  logic             load;
  logic             shift_en;
  logic             sign_ext;
  logic [CNT_W-1:0] bit_idx;
  logic             busy;
  logic             done;
`ifdef SPM_CTRL_ABORT_EN
  logic             abort;

  modport master (
    output start, ack, abort,
    input  ready, load, shift_en, sign_ext, bit_idx, busy, done
  );

  modport slave (
    input  start, ack, abort,
    output ready, load, shift_en, sign_ext, bit_idx, busy, done
  );
`else
  modport master (
    output start, ack,
    input  ready, load, shift_en, sign_ext, bit_idx, busy, done
  );

  modport slave (
    input  start, ack,
    output ready, load, shift_en, sign_ext, bit_idx, busy, done
  );
`endif

endinterface

// File: rtl/spm_bit_counter.sv
// Serial bit counter for the SPM controller: synchronous clear, count
// enable, and a registered terminal flag that is high exactly while the
// count equals the last bit index. The count never wraps past it.
module spm_bit_counter
  import spm_pkg::*;
#(
  parameter int N     = SPM_N,
  parameter int CNT_W = cnt_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(last_bit(N));
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + ONE;

  // Count up while enabled; tc is updated from the incremented value so it
  // is already asserted during the cycle in which count equals LAST.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (en && !tc) begin
      count <= count_inc;
      tc    <= (count_inc == LAST);
    end
  end

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencing controller for the signed serial-parallel multiplier.
// IDLE -> LOAD (one-cycle operand load) -> RUN (2N shift cycles, upper N
// with sign extension) -> DONE (held until ack).
// Optional macro SPM_CTRL_ABORT_EN: abort returns LOAD/RUN/DONE to IDLE
// without producing done; rst still takes priority.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int N     = SPM_N,
  parameter int CNT_W = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  spm_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] N_IDX = CNT_W'(N);

  spm_state_t       state;
  spm_state_t       next_state;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             cnt_clear;
  logic             cnt_en;
  logic             ready_q;
  logic             load_q;
  logic             shift_q;
  logic             busy_q;
  logic             done_q;
  logic             kill;

`ifdef SPM_CTRL_ABORT_EN
  assign kill = bus.abort;
`else
  assign kill = 1'b0;
`endif

  // Next-state decode; start and ack only matter in IDLE and DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = LOAD;
      LOAD:    next_state = RUN;
      RUN:     if (tc) next_state = DONE;
      DONE:    if (bus.ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (kill && (state != IDLE)) next_state = IDLE;
  end

  // State register with Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == IDLE);
      load_q  <= (next_state == LOAD);
      shift_q <= (next_state == RUN);
      busy_q  <= (next_state == LOAD) || (next_state == RUN);
      done_q  <= (next_state == DONE);
    end
  end

  // Hold the counter at zero whenever the controller is not shifting, so
  // it starts from 0 on entry to RUN and is already 0 after leaving it.
  assign cnt_clear = (state != RUN) || (next_state != RUN);
  assign cnt_en    = (state == RUN);

  spm_bit_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (count),
    .tc    (tc)
  );

  assign bus.ready    = ready_q;
  assign bus.load     = load_q;
  assign bus.shift_en = shift_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bit_idx  = shift_q ? count : '0;
  assign bus.sign_ext = shift_q && (count >= N_IDX);

endmodule
